// File: rtl/ks_pkg.sv
// Shared Kogge-Stone definitions for the adder/subtractor datapath blocks.
package ks_pkg;

    localparam int KS_WIDTH        = 21;
    localparam int KS_LEVELS       = 5;
    // Prefix levels evaluated before the mid-pipeline register (spans 1, 2, 4).
    localparam int KS_FRONT_LEVELS = 3;

    typedef struct packed {
        logic [KS_WIDTH-1:0] g;
        logic [KS_WIDTH-1:0] p;
    } gp_t;

    // Subtraction is a + ~b, so generate/propagate are formed against the inverted subtrahend.
    function automatic gp_t gp_sub_init(input logic [KS_WIDTH-1:0] a, input logic [KS_WIDTH-1:0] b);
        gp_t r;
        r.g = a & ~b;
        r.p = a ^ ~b;
        return r;
    endfunction

endpackage

// File: rtl/ks_subtractor_pipe_if.sv
// Operand and result valid/ready streams of the pipelined Kogge-Stone subtractor.
interface ks_subtractor_pipe_if #(parameter int WIDTH = ks_pkg::KS_WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] d;
    logic             bout;
    logic             ovf;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, d, bout, ovf
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, d, bout, ovf
    );

endinterface

// File: rtl/ks_prefix_level.sv
// One combinational Kogge-Stone level: combines each bit with the bit SPAN positions below.
module ks_prefix_level
    import ks_pkg::*;
#(
    parameter int WIDTH = KS_WIDTH,
    parameter int SPAN  = 1
) (
    input  gp_t gp_in,
    output gp_t gp_out
);

    // NOTE: the default assignment first makes every bit driven on every path, so no latch is inferred.
    always_comb begin
        gp_out = gp_in;
        for (int i = SPAN; i < WIDTH; i++) begin
            gp_out.g[i] = gp_in.g[i] | (gp_in.p[i] & gp_in.g[i-SPAN]);
            gp_out.p[i] = gp_in.p[i] & gp_in.p[i-SPAN];
        end
    end

endmodule

// File: rtl/ks_subtractor_pipe.sv
// Three-stage pipelined Kogge-Stone subtractor d = a - b - bin with borrow-out and signed overflow.
module ks_subtractor_pipe
    import ks_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    ks_subtractor_pipe_if.slave  io
);

    localparam int MSB         = KS_WIDTH - 1;
    localparam int BACK_LEVELS = KS_LEVELS - KS_FRONT_LEVELS;

    logic v1, v2, v3;
    logic adv1, adv2, adv3;

    // A stage may load when it is empty or its content moves on, so bubbles collapse under a stall.
    assign adv3        = ~v3 | io.out_ready;
    assign adv2        = ~v2 | adv3;
    assign adv1        = ~v1 | adv2;
    assign io.in_ready = adv1;

    // Stage 1: raw generate/propagate, carry-in and operand sign bits.
    gp_t  s1_gp;
    logic s1_c0, s1_a_msb, s1_b_msb;

    // NOTE: state is assigned with <= so every stage samples the pre-edge values of its neighbours.
    // NOTE: payload registers are reset as well, so d/bout/ovf read 0 straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1       <= 1'b0;
            s1_gp    <= '0;
            s1_c0    <= 1'b0;
            s1_a_msb <= 1'b0;
            s1_b_msb <= 1'b0;
        end else if (adv1) begin
            v1 <= io.in_valid;
            if (io.in_valid) begin
                s1_gp    <= gp_sub_init(io.a, io.b);
                s1_c0    <= ~io.bin;
                s1_a_msb <= io.a[MSB];
                s1_b_msb <= io.b[MSB];
            end
        end
    end

    gp_t front [KS_FRONT_LEVELS+1];
    assign front[0] = s1_gp;

    for (genvar l = 0; l < KS_FRONT_LEVELS; l++) begin : g_front
        ks_prefix_level #(.WIDTH(KS_WIDTH), .SPAN(1 << l)) u_level (
            .gp_in  (front[l]),
            .gp_out (front[l+1])
        );
    end

    // Stage 2: partial prefix plus the original propagate vector needed for the sum.
    gp_t           s2_gp;
    logic [MSB:0]  s2_p;
    logic          s2_c0, s2_a_msb, s2_b_msb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2       <= 1'b0;
            s2_gp    <= '0;
            s2_p     <= '0;
            s2_c0    <= 1'b0;
            s2_a_msb <= 1'b0;
            s2_b_msb <= 1'b0;
        end else if (adv2) begin
            v2 <= v1;
            if (v1) begin
                s2_gp    <= front[KS_FRONT_LEVELS];
                s2_p     <= s1_gp.p;
                s2_c0    <= s1_c0;
                s2_a_msb <= s1_a_msb;
                s2_b_msb <= s1_b_msb;
            end
        end
    end

    gp_t back [BACK_LEVELS+1];
    assign back[0] = s2_gp;

    for (genvar l = 0; l < BACK_LEVELS; l++) begin : g_back
        ks_prefix_level #(.WIDTH(KS_WIDTH), .SPAN(1 << (l + KS_FRONT_LEVELS))) u_level (
            .gp_in  (back[l]),
            .gp_out (back[l+1])
        );
    end

    // Group (G,P) over bits [i:0] gives the carry into bit i+1 once the carry-in is applied.
    logic [KS_WIDTH:0] carry;
    logic [MSB:0]      d_next;
    logic              bout_next, ovf_next;

    assign carry     = {back[BACK_LEVELS].g | (back[BACK_LEVELS].p & {KS_WIDTH{s2_c0}}), s2_c0};
    assign d_next    = s2_p ^ carry[MSB:0];
    assign bout_next = ~carry[KS_WIDTH];
    assign ovf_next  = (s2_a_msb ^ s2_b_msb) & (d_next[MSB] ^ s2_a_msb);

    // Stage 3: registered result, held while the consumer stalls.
    logic [MSB:0] s3_d;
    logic         s3_bout, s3_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v3      <= 1'b0;
            s3_d    <= '0;
            s3_bout <= 1'b0;
            s3_ovf  <= 1'b0;
        end else if (adv3) begin
            v3 <= v2;
            if (v2) begin
                s3_d    <= d_next;
                s3_bout <= bout_next;
                s3_ovf  <= ovf_next;
            end
        end
    end

    assign io.out_valid = v3;
    assign io.d         = s3_d;
    assign io.bout      = s3_bout;
    assign io.ovf       = s3_ovf;

endmodule
